seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: armed by start, matches a latched 1..8 bit pattern
// against the incoming bit stream and counts hits until max_bits or abort.
module seq_det_ctrl #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] pat,
  input  logic [2:0]    pat_len,
  input  logic          overlap,
  input  logic [7:0]    max_bits,
  input  logic          x_valid,
  input  logic          x,
  output logic          busy,
  output logic          z,
  output logic          done,
  output logic [7:0]    match_cnt,
  output logic [1:0]    dbg_state
);

  localparam int FW = $clog2(PW);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [2:0]    len_q, len_d;
  logic          ovl_q, ovl_d;
  logic [7:0]    max_q, max_d;
  logic [PW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    match_cnt_q, match_cnt_d;

  logic          consume;
  logic          match;
  logic          last_bit;
  logic [PW-1:0] cand;
  logic [PW-1:0] mask;
  logic          pat_hit;

  // Only the low L bits of the shifted-in history take part in the compare.
  assign cand     = {hist_q[PW-2:0], x};
  assign mask     = ~({PW{1'b1}} << ({1'b0, len_q} + 4'd1));
  assign pat_hit  = ((cand ^ pat_q) & mask) == '0;
  assign consume  = (state_q == S_RUN) && x_valid && !abort;
  assign match    = consume && (fill_q >= FW'(len_q)) && pat_hit;
  assign last_bit = (max_q != 8'd0) && ((bit_cnt_q + 8'd1) == max_q);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    max_d       = max_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d       = pat;
          len_d       = pat_len;
          ovl_d       = overlap;
          max_d       = max_bits;
          hist_d      = '0;
          fill_d      = '0;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (consume) begin
          hist_d    = cand;
          bit_cnt_d = bit_cnt_q + 8'd1;
          // Non-overlapping mode restarts the window so matched bits are not reused.
          if (match && !ovl_q) begin
            fill_d = '0;
          end else if (fill_q != FW'(PW - 1)) begin
            fill_d = fill_q + FW'(1);
          end
          if (match && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
          if (last_bit) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      max_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      max_q       <= max_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign z         = match;
  assign match_cnt = match_cnt_q;
  assign dbg_state = state_q;

endmodule
